// File: rtl/tu56_fe_store_pkg.sv
// Shared definitions for the tu56 front-end tape-image server: request bit
// positions, motion encodings and the service state machine states.
package tu56_fe_store_pkg;

    localparam int RQ_MOVING  = 0;
    localparam int RQ_REVERSE = 1;
    localparam int RQ_RD      = 2;
    localparam int RQ_WR      = 3;

    localparam int TAPE_LEN_DEFAULT = 922512;

    localparam logic [1:0] STEP_FWD = 2'b10;
    localparam logic [1:0] STEP_REV = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_FE,
        S_RMW_RD,
        S_M_WR,
        S_WR_MRD,
        S_WR_FE,
        S_STEP
    } fe_state_t;

endpackage

// File: rtl/tu56_fe_pos.sv
// Tape line position register: host load, single-line steps in either
// direction, clamping at both tape ends with an end-of-tape flag.
module tu56_fe_pos
    import tu56_fe_store_pkg::*;
#(
    parameter int TAPE_LEN = TAPE_LEN_DEFAULT,
    parameter int POS_INIT = 0,
    parameter int AW       = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic [AW-1:0] i_load_val,
    input  logic          i_step,
    input  logic [1:0]    i_dir,
    output logic [AW-1:0] o_pos,
    output logic          o_at_end,
    output logic          o_in_range
);

    localparam logic [AW-1:0] LAST = AW'(TAPE_LEN - 1);
    localparam logic [AW-1:0] ONE  = AW'(1);

    logic [AW-1:0] r_pos;
    logic          r_at_end;

    // A forward step from beyond the tape end pulls the position back onto the last line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pos    <= AW'(POS_INIT);
            r_at_end <= 1'b0;
        end else if (i_load) begin
            r_pos <= i_load_val;
        end else if (i_step) begin
            case (i_dir)
                STEP_FWD: begin
                    if (r_pos >= LAST) begin
                        r_pos    <= LAST;
                        r_at_end <= 1'b1;
                    end else begin
                        r_pos    <= r_pos + ONE;
                        r_at_end <= 1'b0;
                    end
                end
                STEP_REV: begin
                    if (r_pos == '0) begin
                        r_at_end <= 1'b1;
                    end else begin
                        r_pos    <= r_pos - ONE;
                        r_at_end <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_pos      = r_pos;
    assign o_at_end   = r_at_end;
    assign o_in_range = (r_pos <= LAST);

endmodule

// File: rtl/tu56_fe_store.sv
// Front-end tape-image server: answers tu56 line read/write requests from a
// line-per-byte image in external memory and tracks the tape position.
module tu56_fe_store
    import tu56_fe_store_pkg::*;
#(
    parameter int TAPE_LEN = TAPE_LEN_DEFAULT,
    parameter int POS_INIT = 0,
    parameter int AW       = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [0:3]    fe_rq,
    output logic          fe_address,
    output logic          fe_read,
    output logic          fe_write,
    input  logic [4:0]    fe_readdata,
    output logic [7:0]    fe_writedata,
    output logic [AW-1:0] mem_address,
    output logic          mem_read,
    output logic          mem_write,
    output logic [7:0]    mem_writedata,
    input  logic [7:0]    mem_readdata,
    input  logic          mem_waitrequest,
    input  logic          pos_load,
    input  logic [AW-1:0] pos_in,
    output logic [AW-1:0] pos,
    output logic          at_end,
    output logic          busy
);

    fe_state_t   r_state;
    fe_state_t   w_next;
    logic [1:0]  r_rq_prev;
    logic        r_rd_pend;
    logic        r_wr_pend;
    logic        r_svc_wr;
    logic [1:0]  r_dir;
    logic [3:0]  r_line;

    logic        w_rd_edge;
    logic        w_wr_edge;
    logic        w_rd_req;
    logic        w_wr_req;
    logic        w_in_range;
    logic        w_load;
    logic        w_start;
    logic        w_step;
    logic        w_unused_rd;

    // Including the live edge lets a request start in the same cycle it is first seen.
    assign w_rd_edge   = fe_rq[RQ_RD] & ~r_rq_prev[0];
    assign w_wr_edge   = fe_rq[RQ_WR] & ~r_rq_prev[1];
    assign w_rd_req    = r_rd_pend | w_rd_edge;
    assign w_wr_req    = r_wr_pend | w_wr_edge;
    assign w_load      = (r_state == S_IDLE) && pos_load;
    assign w_start     = (r_state == S_IDLE) && !pos_load && (w_rd_req || w_wr_req);
    assign w_step      = (r_state == S_STEP);
    assign w_unused_rd = ^mem_readdata[7:4];

    tu56_fe_pos #(
        .TAPE_LEN (TAPE_LEN),
        .POS_INIT (POS_INIT),
        .AW       (AW)
    ) u_pos (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (pos_in),
        .i_step     (w_step),
        .i_dir      (r_dir),
        .o_pos      (pos),
        .o_at_end   (at_end),
        .o_in_range (w_in_range)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A new edge in the STEP cycle re-arms the flag being cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rq_prev <= 2'b00;
            r_rd_pend <= 1'b0;
            r_wr_pend <= 1'b0;
            r_svc_wr  <= 1'b0;
            r_dir     <= 2'b00;
            r_line    <= 4'h0;
        end else begin
            r_rq_prev <= {fe_rq[RQ_WR], fe_rq[RQ_RD]};
            if (w_step && !r_svc_wr) r_rd_pend <= 1'b0;
            if (w_step && r_svc_wr)  r_wr_pend <= 1'b0;
            if (w_rd_edge) r_rd_pend <= 1'b1;
            if (w_wr_edge) r_wr_pend <= 1'b1;
            if (w_start) begin
                r_dir    <= {fe_rq[RQ_MOVING], fe_rq[RQ_REVERSE]};
                r_svc_wr <= !w_rd_req;
            end
            case (r_state)
                S_RD_FE:  r_line <= fe_readdata[3:0];
                S_RMW_RD: if (!mem_waitrequest) r_line[3] <= mem_readdata[3];
                S_WR_MRD: begin
                    if (!w_in_range) begin
                        r_line <= 4'h0;
                    end else if (!mem_waitrequest) begin
                        r_line <= mem_readdata[3:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Off-tape positions skip memory entirely; the data path still completes.
    always_comb begin
        w_next        = r_state;
        fe_read       = 1'b0;
        fe_write      = 1'b0;
        fe_writedata  = 8'h00;
        mem_address   = '0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_writedata = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (!pos_load) begin
                    if (w_rd_req)      w_next = S_RD_FE;
                    else if (w_wr_req) w_next = S_WR_MRD;
                end
            end
            S_RD_FE: begin
                fe_read = 1'b1;
                if (!w_in_range)         w_next = S_STEP;
                else if (fe_readdata[4]) w_next = S_M_WR;
                else                     w_next = S_RMW_RD;
            end
            S_RMW_RD: begin
                mem_read    = 1'b1;
                mem_address = pos;
                if (!mem_waitrequest) w_next = S_M_WR;
            end
            S_M_WR: begin
                mem_write     = 1'b1;
                mem_address   = pos;
                mem_writedata = {4'h0, r_line};
                if (!mem_waitrequest) w_next = S_STEP;
            end
            S_WR_MRD: begin
                if (w_in_range) begin
                    mem_read    = 1'b1;
                    mem_address = pos;
                    if (!mem_waitrequest) w_next = S_WR_FE;
                end else begin
                    w_next = S_WR_FE;
                end
            end
            S_WR_FE: begin
                fe_write     = 1'b1;
                fe_writedata = {4'h0, r_line};
                w_next       = S_STEP;
            end
            S_STEP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign fe_address = 1'b0;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: doc/tu56_fe_store.md
Name: tu56_fe_store

Overview:
- Hardware tape-image server on the front-end (FE) side of the tu56 transport model.
- Services the transport's fe_rq read/write requests from a line-per-byte tape image in external memory.
- Tracks the current tape line position and steps it per the transport's motion bits.
- Replaces the software tape simulation so td10 + tu56 can run self-contained on the FPGA.

Parameters:
TAPE_LEN, 922512, number of 4-bit tape lines in the image
POS_INIT, 0, line position loaded on reset
AW, 20, memory address width (2**AW >= TAPE_LEN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
fe_rq  in  4 [0:3]  from tu56: [0]=moving, [1]=reverse, [2]=rd_rq (transport has a line to write to tape), [3]=wr_rq (transport wants a line from tape)
fe_address  out  1  tu56 register select; always 0
fe_read  out  1  read strobe to tu56
fe_write  out  1  write strobe to tu56
fe_readdata  in  5 [4:0]  from tu56: [4]=wrtm (write all 4 tracks), [3:0]=line
fe_writedata  out  8  to tu56: {4'b0, line}
mem_address  out  AW  tape image line address
mem_read  out  1  memory read request
mem_write  out  1  memory write request
mem_writedata  out  8  {4'b0, line}
mem_readdata  in  8  low 4 bits = line; valid when mem_read is high and mem_waitrequest is low
mem_waitrequest  in  1  stall; a request holds all outputs until it is low
pos_load  in  1  host: load position
pos_in  in  AW  host: position value
pos  out  AW  current line position
at_end  out  1  last step was clamped at line 0 or TAPE_LEN-1
busy  out  1  state != IDLE

Behaviour:
- Reset: all strobes 0; fe_writedata=0; mem_address=0; pos=POS_INIT; at_end=0; state=IDLE; pending flags cleared. Reset mid-transaction aborts it with no memory write.
- Edge detect: register fe_rq[2] and fe_rq[3] each cycle. A rising edge sets rd_pend or wr_pend respectively, which stays set until serviced. A second edge while pending is not counted again.
- Direction capture: fe_rq[0:1] is latched at service start.
  - 2'b10: step +1.
  - 2'b11: step -1.
  - 0x: no step.
- IDLE: if rd_pend, go to RD_FE; else if wr_pend, go to WR_MRD. When both are pending simultaneously, rd is serviced first. pos_load is accepted only in IDLE and has priority over starting a request.
- RD_FE (transport to tape):
  - Assert fe_read for exactly one cycle; sample fe_readdata on the closing edge.
  - If bit4=1 (wrtm): line=readdata[3:0]; go to M_WR.
  - Else: go to RMW_RD, read mem[pos], and go to M_WR with line={mem[3], readdata[2:0]}. The mark track is preserved.
- M_WR: mem_write with mem_address=pos and mem_writedata={4'b0, line}; hold until !mem_waitrequest; go to STEP.
- WR_MRD (tape to transport): mem_read at pos; hold until !mem_waitrequest; latch line; go to WR_FE.
- WR_FE: fe_write=1 for exactly one cycle with fe_writedata={4'b0, line}; go to STEP. The position used for the access is the pre-step value.
- STEP:
  - Apply the latched step.
  - -1 at pos 0, or +1 at pos TAPE_LEN-1: pos unchanged and at_end=1.
  - Any successful step clears at_end.
  - Clear the serviced pending flag; return to IDLE.
- pos outside 0..TAPE_LEN-1 (only possible via pos_load): no memory access. WR_FE returns 0; RD_FE discards the data. pos is still stepped/clamped toward the range.
- Latency, zero-wait memory: write-to-tape, wrtm = 3 cycles from edge to IDLE (normal write adds 1 cycle for the RMW read); read-from-tape = 3 cycles; fe_write asserts 2 cycles after the wr_rq edge.

Decomposition:
- Shared package: fe_rq bit indices, step encodings (FWD=2'b10, REV=2'b11), state enum, TAPE_LEN default.
- One sub-module is natural: tu56_fe_pos, holding the position register with load, ±1 step, clamping and at_end.

Test Plan:
1. pos=1581, mem[1581]=8'h05, fe_rq 0000->1001 -> mem_read @1581, one-cycle fe_write with fe_writedata=8'h05, pos=1582, at_end=0.
2. pos=1581, fe_rq 0000->1101 -> fe_writedata=mem[1581], pos=1580.
3. pos=10, mem[10]=4'b1010, fe_readdata=5'b0_0011, fe_rq 0000->1010 -> RMW read then mem_write @10 data 8'h0B, pos=11.
4. pos=10, fe_readdata=5'b1_0110, fe_rq ->1010 -> no memory read, mem_write @10 data 8'h06; with mem_waitrequest held 5 cycles, the write holds stable and completes after the stall.
5. pos_load 0, fe_rq ->1101 -> pos stays 0, at_end=1; pos_load TAPE_LEN-1 and fe_rq ->1001 -> pos unchanged, at_end=1; next valid step clears at_end.
6. Simultaneous rd_rq and wr_rq edges -> rd serviced first, then wr, pos moves by 2. Reset asserted during M_WR stall -> strobes 0, pos=POS_INIT, no write completes.
